// File: rtl/enc_period_queue_if.sv
// rtl/enc_period_queue_if.sv - encoder inputs and period/queue results of one channel
interface enc_period_queue_if #(
    parameter int OW = 22
);
    logic          a;
    logic          b;
    logic [OW-1:0] period;
    logic          period_ovf;
    logic          period_valid;
    logic          dir;
    logic [OW-1:0] q_last;
    logic [OW-1:0] q_old;
    logic [OW-1:0] t_cur;
    logic          edge_pulse;
    logic          err_pulse;
    logic [7:0]    err_cnt;

    modport master (
        output a, b,
        input  period, period_ovf, period_valid, dir, q_last, q_old, t_cur,
        input  edge_pulse, err_pulse, err_cnt
    );

    modport slave (
        input  a, b,
        output period, period_ovf, period_valid, dir, q_last, q_old, t_cur,
        output edge_pulse, err_pulse, err_cnt
    );
endinterface

// File: rtl/enc_period_queue.sv
// rtl/enc_period_queue.sv - quadrature edge timer with a DEPTH-deep queue of quarter-cycle times
module enc_period_queue #(
    parameter  int WIDTH = 26,
    parameter  int DEPTH = 4,
    parameter  int DROP  = 4,
    localparam int OW    = WIDTH - DROP
) (
    input  logic                clk,
    input  logic                reset,
    enc_period_queue_if.slave   bus
);
    localparam int SW = WIDTH + $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [FW-1:0]    FILL_MAX = FW'(DEPTH);
    localparam logic [FW-1:0]    FILL_MIN = FW'(DEPTH - 1);

    logic             a_prev_q, b_prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q [DEPTH];
    logic [WIDTH-1:0] q_d [DEPTH];
    logic [FW-1:0]    fill_q, fill_d;
    logic             dir_q, dir_d;
    logic [OW-1:0]    period_q, period_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             edge_q, edge_d;
    logic             err_q, err_d;
    logic [7:0]       errc_q, errc_d;

    logic [SW-1:0]    sum_w;
    logic             a_chg, b_chg, nd;

    always_comb begin
        // Running sum: current count plus the DEPTH-1 most recent quarters
        sum_w = SW'(cnt_q);
        for (int i = 0; i < DEPTH - 1; i++) begin
            sum_w = sum_w + SW'(q_q[i]);
        end
        a_chg = bus.a ^ a_prev_q;
        b_chg = bus.b ^ b_prev_q;
        nd    = (a_prev_q == bus.b);

        cnt_d    = cnt_q;
        q_d      = q_q;
        fill_d   = fill_q;
        dir_d    = dir_q;
        period_d = period_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        edge_d   = 1'b0;
        err_d    = 1'b0;
        errc_d   = errc_q;

        if (a_chg && b_chg) begin
            err_d   = 1'b1;
            errc_d  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
            cnt_d   = WIDTH'(1);
            fill_d  = '0;
            valid_d = 1'b0;
        end else if (a_chg || b_chg) begin
            q_d[0] = cnt_q;
            for (int i = 1; i < DEPTH; i++) begin
                q_d[i] = q_q[i-1];
            end
            cnt_d  = WIDTH'(1);
            edge_d = 1'b1;
            dir_d  = nd;
            if (sum_w > SW'(MAX)) begin
                period_d = '1;
                ovf_d    = 1'b1;
            end else begin
                period_d = sum_w[WIDTH-1:DROP];
                ovf_d    = 1'b0;
            end
            if (cnt_q == MAX)           fill_d = '0;
            else if (nd != dir_q)       fill_d = FW'(1);
            else if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
            valid_d = (nd == dir_q) && (fill_q >= FILL_MIN) && (cnt_q != MAX);
        end else if (cnt_q == MAX) begin
            period_d = '1;
            ovf_d    = 1'b1;
        end else begin
            // Stalled longer than the oldest quarter: let the period grow live
            if (cnt_q >= q_q[DEPTH-1]) begin
                if (sum_w > SW'(MAX)) begin
                    period_d = '1;
                    ovf_d    = 1'b1;
                end else begin
                    period_d = sum_w[WIDTH-1:DROP];
                    ovf_d    = 1'b0;
                end
            end
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_prev_q <= bus.a;
            b_prev_q <= bus.b;
            cnt_q    <= MAX;
            for (int i = 0; i < DEPTH; i++) q_q[i] <= MAX;
            fill_q   <= '0;
            dir_q    <= 1'b0;
            period_q <= '1;
            ovf_q    <= 1'b1;
            valid_q  <= 1'b0;
            edge_q   <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= 8'd0;
        end else begin
            a_prev_q <= bus.a;
            b_prev_q <= bus.b;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            fill_q   <= fill_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            edge_q   <= edge_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_ovf   = ovf_q;
    assign bus.period_valid = valid_q;
    assign bus.dir          = dir_q;
    assign bus.q_last       = q_q[0][WIDTH-1:DROP];
    assign bus.q_old        = q_q[DEPTH-1][WIDTH-1:DROP];
    assign bus.t_cur        = cnt_q[WIDTH-1:DROP];
    assign bus.edge_pulse   = edge_q;
    assign bus.err_pulse    = err_q;
    assign bus.err_cnt      = errc_q;
endmodule

// File: tb/tb_enc_period_queue.sv
// tb/tb_enc_period_queue.sv - wide (26-bit) and narrow (12-bit) channels against a queue model
module tb_enc_period_queue;
    localparam int D  = 4;
    localparam int DR = 4;

    logic clk = 1'b0;
    logic rst_r = 1'b1;
    logic a_r = 1'b1;
    logic b_r = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pos = 1;

    always #5 clk = ~clk;

    enc_period_queue_if #(.OW(22)) bus_w ();
    enc_period_queue_if #(.OW(8))  bus_n ();
    assign bus_w.a = a_r;
    assign bus_w.b = b_r;
    assign bus_n.a = a_r;
    assign bus_n.b = b_r;

    enc_period_queue #(.WIDTH(26), .DEPTH(D), .DROP(DR)) dut_w (.clk(clk), .reset(rst_r), .bus(bus_w));
    enc_period_queue #(.WIDTH(12), .DEPTH(D), .DROP(DR)) dut_n (.clk(clk), .reset(rst_r), .bus(bus_n));

    // Reference state, index 0 = wide channel, 1 = narrow channel
    longint mx_of [2];
    longint m_cnt [2];
    longint m_q   [2][D];
    longint m_per [2];
    int     m_fill[2];
    int     m_errc[2];
    bit     m_ovf[2], m_val[2], m_dir[2], m_edge[2], m_err[2], m_ad[2], m_bd[2];

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        longint mx, s;
        bit ea, eb, nd;
        mx = mx_of[k];
        if (rst_r) begin
            m_cnt[k] = mx;
            for (int i = 0; i < D; i++) m_q[k][i] = mx;
            m_fill[k] = 0; m_errc[k] = 0; m_per[k] = mx >> DR;
            m_ovf[k] = 1; m_val[k] = 0; m_dir[k] = 0; m_edge[k] = 0; m_err[k] = 0;
            m_ad[k] = a_r; m_bd[k] = b_r;
            return;
        end
        ea = (a_r != m_ad[k]);
        eb = (b_r != m_bd[k]);
        s = m_cnt[k];
        for (int i = 0; i < D - 1; i++) s += m_q[k][i];
        m_edge[k] = 0;
        m_err[k] = 0;
        if (ea && eb) begin
            m_err[k] = 1;
            if (m_errc[k] < 255) m_errc[k]++;
            m_cnt[k] = 1; m_fill[k] = 0; m_val[k] = 0;
        end else if (ea || eb) begin
            nd = (m_ad[k] == b_r);
            m_val[k] = (nd == m_dir[k]) && (m_fill[k] >= D - 1) && (m_cnt[k] != mx);
            if (m_cnt[k] == mx) m_fill[k] = 0;
            else if (nd != m_dir[k]) m_fill[k] = 1;
            else m_fill[k] = (m_fill[k] + 1 > D) ? D : m_fill[k] + 1;
            m_ovf[k] = (s > mx);
            m_per[k] = (s > mx) ? (mx >> DR) : (s >> DR);
            for (int i = D - 1; i > 0; i--) m_q[k][i] = m_q[k][i-1];
            m_q[k][0] = m_cnt[k];
            m_cnt[k] = 1; m_edge[k] = 1; m_dir[k] = nd;
        end else if (m_cnt[k] == mx) begin
            m_ovf[k] = 1;
            m_per[k] = mx >> DR;
        end else begin
            if (m_cnt[k] >= m_q[k][D-1]) begin
                m_ovf[k] = (s > mx);
                m_per[k] = (s > mx) ? (mx >> DR) : (s >> DR);
            end
            m_cnt[k]++;
        end
        m_ad[k] = a_r;
        m_bd[k] = b_r;
    endtask

    task automatic compare_all();
        check("w.period", bus_w.period, m_per[0]);
        check("w.ovf", bus_w.period_ovf, m_ovf[0]);
        check("w.valid", bus_w.period_valid, m_val[0]);
        check("w.dir", bus_w.dir, m_dir[0]);
        check("w.q_last", bus_w.q_last, m_q[0][0] >> DR);
        check("w.q_old", bus_w.q_old, m_q[0][D-1] >> DR);
        check("w.t_cur", bus_w.t_cur, m_cnt[0] >> DR);
        check("w.edge", bus_w.edge_pulse, m_edge[0]);
        check("w.err", bus_w.err_pulse, m_err[0]);
        check("w.err_cnt", bus_w.err_cnt, m_errc[0]);
        check("n.period", bus_n.period, m_per[1]);
        check("n.ovf", bus_n.period_ovf, m_ovf[1]);
        check("n.valid", bus_n.period_valid, m_val[1]);
        check("n.dir", bus_n.dir, m_dir[1]);
        check("n.q_last", bus_n.q_last, m_q[1][0] >> DR);
        check("n.q_old", bus_n.q_old, m_q[1][D-1] >> DR);
        check("n.t_cur", bus_n.t_cur, m_cnt[1] >> DR);
        check("n.edge", bus_n.edge_pulse, m_edge[1]);
        check("n.err", bus_n.err_pulse, m_err[1]);
        check("n.err_cnt", bus_n.err_cnt, m_errc[1]);
    endtask

    // Called just after a falling edge: drive, predict the next rising edge, sample at the next falling edge
    task automatic step(input logic na, input logic nb, input logic nr);
        a_r = na;
        b_r = nb;
        rst_r = nr;
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(a_r, b_r, 1'b0);
    endtask

    // Gray position 0..3 = {a,b} 00,10,11,01; forward is increasing position
    task automatic legal(input bit fwd);
        pos = fwd ? (pos + 1) % 4 : (pos + 3) % 4;
        step(pos == 1 || pos == 2, pos == 2 || pos == 3, 1'b0);
    endtask

    task automatic illegal();
        pos = (pos + 2) % 4;
        step(~a_r, ~b_r, 1'b0);
    endtask

    initial begin
        int r;
        mx_of[0] = (longint'(1) << 26) - 1;
        mx_of[1] = (longint'(1) << 12) - 1;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(3);
        check("rst.edge", bus_w.edge_pulse, 0);
        check("rst.period", bus_w.period, 22'h3FFFFF);
        check("rst.ovf", bus_w.period_ovf, 1);
        check("rst.valid", bus_w.period_valid, 0);
        check("rst.t_cur", bus_w.t_cur, 22'h3FFFFF);

        for (int e = 1; e <= 5; e++) begin
            legal(1'b1);
            if (e == 5) begin
                check("fwd5.period", bus_w.period, 25);
                check("fwd5.valid", bus_w.period_valid, 1);
                check("fwd5.ovf", bus_w.period_ovf, 0);
                check("fwd5.dir", bus_w.dir, 1);
                check("fwd5.q_last", bus_w.q_last, 6);
            end
            idle(99);
        end
        legal(1'b1);
        idle(99);
        for (int e = 1; e <= 6; e++) begin
            legal(1'b0);
            if (e == 1) begin
                check("rev1.valid", bus_w.period_valid, 0);
                check("rev1.dir", bus_w.dir, 0);
            end
            if (e == 3) check("rev3.valid", bus_w.period_valid, 0);
            if (e == 4) check("rev4.valid", bus_w.period_valid, 1);
            idle(99);
        end

        idle(4200);
        check("stall.n.period", bus_n.period, 8'hFF);
        check("stall.n.ovf", bus_n.period_ovf, 1);
        check("stall.n.t_cur", bus_n.t_cur, 8'hFF);
        legal(1'b0);
        check("stall.n.valid", bus_n.period_valid, 0);
        idle(20);

        illegal();
        check("ill.err_pulse", bus_w.err_pulse, 1);
        check("ill.err_cnt", bus_w.err_cnt, 1);
        check("ill.valid", bus_w.period_valid, 0);
        idle(1);
        check("ill.pulse_off", bus_w.err_pulse, 0);
        for (int i = 0; i < 299; i++) illegal();
        check("ill.err_sat", bus_w.err_cnt, 255);

        legal(1'b1);
        idle(56);
        check("mid.t_cur", bus_w.t_cur, 57 >> DR);
        step(a_r, b_r, 1'b1);
        check("mid.err_cnt", bus_w.err_cnt, 0);
        check("mid.period", bus_w.period, 22'h3FFFFF);
        check("mid.ovf", bus_w.period_ovf, 1);
        check("mid.valid", bus_w.period_valid, 0);

        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) illegal();
            else if (r < 3) step(a_r, b_r, 1'b1);
            else if (r < 13) legal($urandom_range(0, 9) < 8);
            else step(a_r, b_r, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
